// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM arbiter: fixed-priority VGA scanout with 2x2 pixel doubling,
// host valid/ready port in the remaining cycles, registered 4:4:4 colour out.
module vram_scan_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 12,
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 480,
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic [11:0]           in_h_position,
    input  logic [11:0]           in_v_position,
    input  logic                  in_enable,
    input  logic [11:0]           in_border_rgb,
    input  logic                  in_host_valid,
    input  logic                  in_host_write,
    input  logic [ADDR_WIDTH-1:0] in_host_addr,
    input  logic [DATA_WIDTH-1:0] in_host_wdata,
    output logic                  out_host_ready,
    output logic                  out_host_rvalid,
    output logic [DATA_WIDTH-1:0] out_host_rdata,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic                  out_mem_we,
    output logic [DATA_WIDTH-1:0] out_mem_wdata,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
    output logic [3:0]            out_vga_r,
    output logic [3:0]            out_vga_g,
    output logic [3:0]            out_vga_b,
    output logic                  out_frame_start
);

    logic                  r_en;
    logic                  r_frame_start;
    logic                  r_rvalid;
    logic [11:0]           r_rgb;

    logic [12:0]           w_h2_sum;
    logic [11:0]           w_h2;
    logic [11:0]           w_tv;
    logic [12:0]           w_h1_sum;
    logic [11:0]           w_h1;
    logic [11:0]           w_v1;
    logic [11:0]           w_v_next;
    logic                  w_slot;
    logic                  w_accept;
    logic                  w_latch_pt;
    logic                  w_h1_vis;
    logic [ADDR_WIDTH-1:0] w_scan_addr;
    logic [11:0]           w_rgb_next;

    assign w_v_next = (in_v_position == 12'(V_TOTAL - 1)) ?
                      12'd0 : in_v_position + 12'd1;

    // Fetch runs two columns ahead; colour register loads one column ahead.
    always_comb begin
        w_h2_sum = {1'b0, in_h_position} + 13'd2;
        w_h2     = w_h2_sum[11:0];
        w_tv     = in_v_position;
        if (w_h2_sum >= 13'(H_TOTAL)) begin
            w_h2 = 12'(w_h2_sum - 13'(H_TOTAL));
            w_tv = w_v_next;
        end
    end

    always_comb begin
        w_h1_sum = {1'b0, in_h_position} + 13'd1;
        w_h1     = w_h1_sum[11:0];
        w_v1     = in_v_position;
        if (w_h1_sum >= 13'(H_TOTAL)) begin
            w_h1 = 12'(w_h1_sum - 13'(H_TOTAL));
            w_v1 = w_v_next;
        end
    end

    assign w_slot = r_en && (w_h2 < 12'(H_VISIBLE)) && !w_h2[0] &&
                    (w_tv < 12'(V_VISIBLE));

    assign w_scan_addr = ADDR_WIDTH'(32'(w_tv[11:1]) * 32'(FB_WIDTH) +
                                     32'(w_h2[11:1]));

    assign w_accept = in_host_valid && !w_slot && !reset;

    always_comb begin
        out_host_ready = !w_slot;
        out_mem_addr   = w_slot ? w_scan_addr : in_host_addr;
        out_mem_we     = w_accept && in_host_write;
        out_mem_wdata  = in_host_wdata;
    end

    assign w_latch_pt = (in_h_position == 12'(H_TOTAL - 3)) &&
                        (in_v_position == 12'(V_TOTAL - 1));

    assign w_h1_vis = (w_h1 < 12'(H_VISIBLE)) && (w_v1 < 12'(V_VISIBLE));

    // Odd columns repeat the pair's word; bus data is stale by then.
    always_comb begin
        w_rgb_next = 12'd0;
        if (w_h1_vis) begin
            if (!r_en)
                w_rgb_next = in_border_rgb;
            else if (!w_h1[0])
                w_rgb_next = in_mem_rdata[11:0];
            else
                w_rgb_next = r_rgb;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_en          <= 1'b0;
            r_frame_start <= 1'b0;
            r_rvalid      <= 1'b0;
            r_rgb         <= 12'd0;
        end else begin
            r_frame_start <= w_latch_pt;
            if (w_latch_pt)
                r_en <= in_enable;
            r_rvalid <= w_accept && !in_host_write;
            r_rgb    <= w_rgb_next;
        end
    end

    assign out_host_rvalid = r_rvalid;
    assign out_host_rdata  = r_rvalid ? in_mem_rdata : '0;
    assign out_vga_r       = r_rgb[11:8];
    assign out_vga_g       = r_rgb[7:4];
    assign out_vga_b       = r_rgb[3:0];
    assign out_frame_start = r_frame_start;

endmodule
